// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the memory stage (master) and the memory (slave).
interface mem_stage_if;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, wr, addr, wdata, be, input rdata, ack);
  modport slave  (input req, wr, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues loads/stores on a req/ack bus, aligns load data, feeds MEM_WB.
// Zero-wait ops complete in the request cycle; a pending ack stalls upstream and bubbles MEM_WB.
module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_mem_valid,
  input  logic               ex_mem_regfile_re,
  input  logic               ex_mem_regfile_we,
  input  logic [4:0]         ex_mem_regfile_addr,
  input  logic [31:0]        ex_mem_alu_result,
  input  logic [31:0]        ex_mem_store_data,
  input  logic [3:0]         ex_mem_mem_op,
  mem_stage_if.master        dmem,
  output logic               mem_wb_regfile_re,
  output logic               mem_wb_regfile_we,
  output logic [4:0]         mem_wb_regfile_addr,
  output logic [31:0]        mem_wb_data,
  output logic               mem_stall,
  output logic               mem_misalign,
  output logic               mem_bus_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    r_op;
  logic [31:0]   r_addr, r_wdata;
  logic [3:0]    r_be;
  logic [4:0]    r_rd;
  logic          r_we, r_re;

  logic [3:0]    op;
  logic          is_mem, is_load, r_is_load, misalign;
  logic          req, capture, cnt_inc;

  function automatic logic [3:0] lane_be(input logic [3:0] o, input logic [1:0] a);
    case (o)
      OP_LB, OP_LBU, OP_SB: lane_be = 4'b0001 << a;
      OP_LH, OP_LHU, OP_SH: lane_be = a[1] ? 4'b1100 : 4'b0011;
      default:              lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] st_data(input logic [3:0] o, input logic [31:0] d);
    case (o)
      OP_SB:   st_data = {4{d[7:0]}};
      OP_SH:   st_data = {2{d[15:0]}};
      default: st_data = d;
    endcase
  endfunction

  function automatic logic [31:0] ld_align(input logic [3:0] o, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [31:0] sh;
    sh = d >> {a, 3'b000};
    case (o)
      OP_LB:   ld_align = {{24{sh[7]}}, sh[7:0]};
      OP_LBU:  ld_align = {24'h0, sh[7:0]};
      OP_LH:   ld_align = {{16{sh[15]}}, sh[15:0]};
      OP_LHU:  ld_align = {16'h0, sh[15:0]};
      default: ld_align = d;
    endcase
  endfunction

  // Invalid slots behave exactly like a non-memory op.
  assign op        = ex_mem_valid ? ex_mem_mem_op : 4'd0;
  assign is_mem    = (op >= OP_LB) && (op <= OP_SW);
  assign is_load   = (op >= OP_LB) && (op <= OP_LW);
  assign r_is_load = (r_op >= OP_LB) && (r_op <= OP_LW);
  assign misalign  = (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && ex_mem_alu_result[0])
                   || (((op == OP_LW) || (op == OP_SW)) && (ex_mem_alu_result[1:0] != 2'b00));

  // Bus fields are zero whenever no request is up, which also covers reset.
  always_comb begin
    dmem.req   = req;
    dmem.wr    = 1'b0;
    dmem.addr  = '0;
    dmem.wdata = '0;
    dmem.be    = '0;
    if (req) begin
      if (state == BUSY) begin
        dmem.wr    = r_op >= OP_SB;
        dmem.addr  = {r_addr[31:2], 2'b00};
        dmem.wdata = r_wdata;
        dmem.be    = r_be;
      end else begin
        dmem.wr    = op >= OP_SB;
        dmem.addr  = {ex_mem_alu_result[31:2], 2'b00};
        dmem.wdata = st_data(op, ex_mem_store_data);
        dmem.be    = lane_be(op, ex_mem_alu_result[1:0]);
      end
    end
  end

  always_comb begin
    state_nxt           = state;
    req                 = 1'b0;
    capture             = 1'b0;
    cnt_inc             = 1'b0;
    mem_stall           = 1'b0;
    mem_misalign        = 1'b0;
    mem_bus_err         = 1'b0;
    mem_wb_regfile_re   = 1'b0;
    mem_wb_regfile_we   = 1'b0;
    mem_wb_regfile_addr = '0;
    mem_wb_data         = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          mem_wb_regfile_re   = ex_mem_regfile_re;
          mem_wb_regfile_addr = ex_mem_regfile_addr;
          mem_wb_data         = ex_mem_alu_result;
          if (!is_mem) begin
            mem_wb_regfile_we = ex_mem_regfile_we & ex_mem_valid;
          end else if (misalign) begin
            mem_misalign = 1'b1;
          end else begin
            req = 1'b1;
            if (dmem.ack) begin
              mem_wb_regfile_we = is_load & ex_mem_regfile_we;
              if (is_load) mem_wb_data = ld_align(op, ex_mem_alu_result[1:0], dmem.rdata);
            end else begin
              mem_stall           = 1'b1;
              mem_wb_regfile_re   = 1'b0;
              mem_wb_regfile_addr = '0;
              mem_wb_data         = '0;
              capture             = 1'b1;
              state_nxt           = BUSY;
            end
          end
        end
        BUSY: begin
          // An ack arriving on the timeout cycle still completes the transfer.
          if (dmem.ack) begin
            req                 = 1'b1;
            mem_wb_regfile_re   = r_re;
            mem_wb_regfile_we   = r_is_load & r_we;
            mem_wb_regfile_addr = r_rd;
            mem_wb_data         = r_is_load ? ld_align(r_op, r_addr[1:0], dmem.rdata) : r_addr;
            state_nxt           = IDLE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            mem_bus_err = 1'b1;
            state_nxt   = IDLE;
          end else begin
            req       = 1'b1;
            mem_stall = 1'b1;
            cnt_inc   = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rd    <= '0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        cnt     <= '0;
        r_op    <= op;
        r_addr  <= ex_mem_alu_result;
        r_wdata <= st_data(op, ex_mem_store_data);
        r_be    <= lane_be(op, ex_mem_alu_result[1:0]);
        r_rd    <= ex_mem_regfile_addr;
        r_we    <= ex_mem_regfile_we;
        r_re    <= ex_mem_regfile_re;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded random bench for mem_stage: driver pushes expected retirements, monitor compares.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_valid, ex_mem_regfile_re, ex_mem_regfile_we;
  logic [4:0]  ex_mem_regfile_addr;
  logic [31:0] ex_mem_alu_result, ex_mem_store_data;
  logic [3:0]  ex_mem_mem_op;
  logic        mem_wb_regfile_re, mem_wb_regfile_we;
  logic [4:0]  mem_wb_regfile_addr;
  logic [31:0] mem_wb_data;
  logic        mem_stall, mem_misalign, mem_bus_err;

  mem_stage_if dmem ();

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ex_mem_valid        (ex_mem_valid),
    .ex_mem_regfile_re   (ex_mem_regfile_re),
    .ex_mem_regfile_we   (ex_mem_regfile_we),
    .ex_mem_regfile_addr (ex_mem_regfile_addr),
    .ex_mem_alu_result   (ex_mem_alu_result),
    .ex_mem_store_data   (ex_mem_store_data),
    .ex_mem_mem_op       (ex_mem_mem_op),
    .dmem                (dmem),
    .mem_wb_regfile_re   (mem_wb_regfile_re),
    .mem_wb_regfile_we   (mem_wb_regfile_we),
    .mem_wb_regfile_addr (mem_wb_regfile_addr),
    .mem_wb_data         (mem_wb_data),
    .mem_stall           (mem_stall),
    .mem_misalign        (mem_misalign),
    .mem_bus_err         (mem_bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic        re;
    logic        chk_re;
    logic [31:0] data;
    logic        mis;
    logic        err;
    int          stall;
    logic        mem;
    logic        req_end;
    logic        wr;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [3:0]  be;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   stall_cnt = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input int op, input int lane, input logic [31:0] r);
    logic [31:0] v;
    v = r >> (8 * lane);
    case (op)
      1: begin v = v & 32'hFF;   if (v >= 128)   v = v - 256;   end
      2: v = v & 32'hFF;
      3: begin v = v & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      4: v = v & 32'hFFFF;
      default: v = r;
    endcase
    return v;
  endfunction

  function automatic logic [68:0] bus_act(input exp_t e);
    return {dmem.wr, dmem.addr, e.wr ? dmem.wdata : 32'h0, e.wr ? dmem.be : 4'h0};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", {dmem.req, dmem.wr, dmem.addr, dmem.wdata, dmem.be, mem_wb_regfile_re,
                            mem_wb_regfile_we, mem_wb_regfile_addr, mem_wb_data, mem_stall,
                            mem_misalign, mem_bus_err}, '0);
      stall_cnt = 0;
    end else if (mon_en) begin
      chk("pending_txn", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb[0];
        if (mem_stall) begin
          stall_cnt++;
          chk("bubble_wb", {mem_wb_regfile_we, mem_wb_regfile_re}, 0);
          chk("stall_req", dmem.req, e.mem);
          if (e.mem) chk("stall_bus", bus_act(e), {e.wr, e.baddr, e.bwdata, e.be});
        end else begin
          void'(sb.pop_front());
          chk("stall_cycles", stall_cnt, e.stall);
          stall_cnt = 0;
          chk("misalign", mem_misalign, e.mis);
          chk("bus_err", mem_bus_err, e.err);
          chk("wb_we", mem_wb_regfile_we, e.we);
          if (e.we) begin
            chk("wb_data", mem_wb_data, e.data);
            chk("wb_rd", mem_wb_regfile_addr, e.rd);
          end
          if (e.chk_re) chk("wb_re", mem_wb_regfile_re, e.re);
          chk("done_req", dmem.req, e.req_end);
          if (e.req_end) chk("done_bus", bus_act(e), {e.wr, e.baddr, e.bwdata, e.be});
        end
      end
    end else begin
      stall_cnt = 0;
    end
  end

  task automatic scramble();
    ex_mem_valid        = 1'($urandom);
    ex_mem_regfile_re   = 1'($urandom);
    ex_mem_regfile_we   = 1'($urandom);
    ex_mem_regfile_addr = 5'($urandom);
    ex_mem_alu_result   = $urandom;
    ex_mem_store_data   = $urandom;
    ex_mem_mem_op       = 4'($urandom);
  endtask

  task automatic issue(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rdat, input logic [4:0] rd,
                       input logic we, input logic re, input int d);
    exp_t e;
    logic mem, ld, st, mis;
    int   lane, last;
    mem  = v && (op >= 1) && (op <= 8);
    ld   = mem && (op <= 5);
    st   = mem && (op >= 6);
    lane = int'(a[1:0]);
    mis  = mem && ((((op == 3) || (op == 4) || (op == 7)) && a[0]) ||
                   (((op == 5) || (op == 8)) && (lane != 0)));
    e = '0;
    e.rd = rd; e.re = re; e.chk_re = 1'b1; e.mis = mis;
    last = 0;
    if (!mem) begin
      e.we = we & v;
      e.data = a;
    end else if (mis) begin
      e.chk_re = 1'b0;
    end else begin
      e.mem = 1'b1;
      e.wr = st;
      e.baddr = a & 32'hFFFF_FFFC;
      if (st) begin
        e.bwdata = (op == 6) ? (sd & 32'hFF) * 32'h0101_0101 :
                   (op == 7) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
        e.be = (op == 6) ? 4'(1 << lane) : (op == 7) ? 4'(3 << lane) : 4'hF;
      end
      if (d <= TO) begin
        last = d; e.stall = d; e.req_end = 1'b1;
        e.we = ld & we;
        if (ld) e.data = model_load(int'(op), lane, rdat);
      end else begin
        last = TO; e.stall = TO; e.err = 1'b1; e.chk_re = 1'b0;
      end
    end
    sb.push_back(e);
    for (int j = 0; j <= last; j++) begin
      if (j == 0) begin
        ex_mem_valid = v; ex_mem_mem_op = op; ex_mem_alu_result = a;
        ex_mem_store_data = sd; ex_mem_regfile_addr = rd;
        ex_mem_regfile_we = we; ex_mem_regfile_re = re;
      end else begin
        scramble();
      end
      dmem.ack   = mem && !mis && (j == d);
      dmem.rdata = (j == d) ? rdat : $urandom;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    dmem.ack = 1'b0;
    dmem.rdata = '0;
    scramble();
    repeat (3) begin
      @(posedge clk); #1;
      scramble();
      dmem.ack = 1'($urandom);
    end
    rst = 1'b0;
    mon_en = 1'b1;

    issue(1, 0, 32'h1234_5678, 0, 0, 5, 1, 1, 0);
    issue(1, 1, 32'h103, 0, 32'h80FF_0000, 7, 1, 0, 0);
    issue(1, 2, 32'h103, 0, 32'h80FF_0000, 7, 1, 0, 0);
    issue(1, 7, 32'h202, 32'hABCD_1234, 0, 3, 1, 1, 3);
    issue(1, 5, 32'h105, 0, 0, 9, 1, 1, 0);
    issue(1, 5, 32'h400, 0, 32'h5555_AAAA, 10, 1, 1, 99);
    issue(1, 5, 32'h404, 0, 32'h1357_9BDF, 11, 1, 1, TO);
    issue(0, 5, 32'h408, 0, 0, 12, 1, 1, 0);

    // Reset arrives in the second BUSY cycle; the late ack afterwards must be ignored.
    mon_en = 1'b0;
    ex_mem_valid = 1'b1; ex_mem_mem_op = 4'd5; ex_mem_alu_result = 32'h300;
    ex_mem_regfile_we = 1'b1; dmem.ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ex_mem_valid = 1'b0;
    dmem.ack = 1'b1;
    dmem.rdata = $urandom;
    @(negedge clk);
    chk("rst_abort_req", dmem.req, 0);
    chk("rst_abort_stall", mem_stall, 0);
    chk("rst_abort_we", mem_wb_regfile_we, 0);
    @(posedge clk); #1;
    dmem.ack = 1'b0;
    mon_en = 1'b1;
    issue(1, 5, 32'h300, 0, 32'hCAFE_F00D, 4, 1, 1, 2);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [3:0]  op;
      int          d;
      op = 4'($urandom);
      a  = {20'h0, 12'($urandom)};
      if ($urandom_range(1) == 1) begin
        if (op == 3 || op == 4 || op == 7) a[0] = 1'b0;
        if (op == 5 || op == 8) a[1:0] = 2'b00;
      end
      d = ($urandom_range(9) < 6) ? int'($urandom_range(2)) : int'($urandom_range(6, 3));
      issue(($urandom_range(9) != 0), op, a, $urandom, $urandom, 5'($urandom),
            1'($urandom), 1'($urandom), d);
    end

    mon_en = 1'b0;
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline, between the EX/MEM register and the MEM_WB register. Performs loads and stores over a req/ack data-memory bus, aligns and extends load data, and drives the register-file writeback fields into MEM_WB. MEM_WB has no enable, so this block stalls upstream and feeds bubbles downstream while a bus transfer is in flight. It also aborts transfers that exceed a timeout.

## Interface
- TIMEOUT, 255: maximum number of BUSY cycles without ack before the transfer aborts; counter width is clog2(TIMEOUT+1).
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- ex_mem_valid  in  1  EX/MEM holds a real instruction
- ex_mem_regfile_re  in  1  register-file read flag, passed through
- ex_mem_regfile_we  in  1  register-file write enable
- ex_mem_regfile_addr  in  5  destination register
- ex_mem_alu_result  in  32  ALU result, or effective address for memory ops
- ex_mem_store_data  in  32  rt value for stores
- ex_mem_mem_op  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 treated as none
- dmem_req  out  1  bus request
- dmem_wr  out  1  1 = store
- dmem_addr  out  32  word address {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables; bit i = byte lane i, little-endian
- dmem_rdata  in  32  read data, valid only in an ack cycle
- dmem_ack  in  1  transfer complete, sampled every cycle dmem_req=1
- mem_wb_regfile_re / mem_wb_regfile_we  out  1 / 1  to MEM_WB
- mem_wb_regfile_addr  out  5  to MEM_WB
- mem_wb_data  out  32  to MEM_WB
- mem_stall  out  1  hold PC/IF/ID/EX/EX_MEM
- mem_misalign  out  1  one-cycle misaligned-access pulse
- mem_bus_err  out  1  one-cycle timeout pulse

## Operation
- FSM states: IDLE and BUSY. The request registers (op, address, wdata, be, regfile addr/we/re) capture on the IDLE->BUSY edge. In BUSY, the bus is driven only from these registers.
- Non-memory op, or ex_mem_valid=0: outputs pass through combinationally. mem_wb_data=ex_mem_alu_result. we=ex_mem_regfile_we&ex_mem_valid. No request.
- Misalignment, checked in IDLE: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0. Response: no request, mem_misalign=1 for that cycle, mem_wb_regfile_we=0, no stall.
- Aligned memory op in IDLE: dmem_req=1 combinationally with the IDLE-cycle fields.
  - ack in the same cycle: the op completes, no stall, FSM stays IDLE.
  - no ack: mem_stall=1, next state is BUSY.
- BUSY: dmem_req=1 and all bus fields held stable. mem_stall=1, and mem_wb_regfile_we=0 and re=0 (bubble into MEM_WB).
  - ack: mem_stall=0, the result is driven from the registers, next state is IDLE.
- Store encoding:
  - SB: wdata={4{b}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{h}}, be=addr[1]?4'b1100:4'b0011.
  - SW: be=4'b1111.
- Stores: mem_wb_regfile_we=0 on completion.
- Loads: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend. mem_wb_data=aligned value on the ack cycle, we=latched/live regfile_we.
- Timeout: the counter clears on IDLE->BUSY and increments each BUSY cycle without ack. On reaching TIMEOUT:
  - dmem_req drops that cycle.
  - mem_bus_err=1 and mem_stall=0.
  - we=0, next state is IDLE.
  - ack and timeout in the same cycle: ack wins.

## Timing
- Reset: state is IDLE and the counter is 0. While rst=1, every output is 0, including dmem_req, mem_stall, mem_wb_* and both error pulses.
- rst asserted during BUSY: the request is dropped at the next edge. A late ack is ignored because dmem_req=0.
- Zero-wait load: result presented in the request cycle. MEM_WB captures it at the following edge; latency 0 stall cycles.
- ack k cycles after the first req cycle: mem_stall is high exactly k cycles, MEM_WB captures k bubbles, and the result appears in cycle k.
- Back-to-back memory ops: the next op issues in IDLE on the cycle after completion. A zero-wait stream sustains 1 op/cycle.
- mem_misalign and mem_bus_err are each high for exactly one cycle and never high together.

## Test plan
- ADD result 0x12345678 → rd 5, op 0 → same cycle: mem_wb_data=0x12345678, we=1, dmem_req=0, stall=0.
- LB addr 0x103 with zero-wait ack, rdata=0x80FF_0000 → be ignored, dmem_addr=0x100, mem_wb_data=0xFFFFFF80, we=1, no stall. Repeat as LBU → 0x00000080.
- SH addr 0x202, data 0xABCD1234, ack 3 cycles late → dmem_wdata=0x12341234, be=4'b1100, stall high 3 cycles with bubbles (we=0), fields stable throughout, we=0 at completion.
- LW addr 0x105 → mem_misalign pulse 1 cycle, dmem_req=0, we=0, stall=0.
- TIMEOUT=4, LW with no ack → stall 4 cycles, then mem_bus_err=1, req=0, stall=0, we=0, FSM back to IDLE. Repeat with ack on the timeout cycle → normal completion, no error.
- rst asserted in the 2nd BUSY cycle → next cycle req=0, stall=0, all outputs 0; a subsequent LW completes normally.
